// File: rtl/tcp_vlg_rx_seq_trk_pkg.sv
// Shared types for the TCP RX sequence tracker: segment classes, stored
// out-of-order ranges and the 32-bit wrap-aware sequence comparison.
package tcp_vlg_pkg;

  typedef enum logic [2:0] {
    EMPTY    = 3'd0,
    IN_ORDER = 3'd1,
    DUP      = 3'd2,
    OOO      = 3'd3,
    DROP     = 3'd4
  } seq_class_t;

  typedef struct packed {
    logic        val;
    logic [31:0] start;
    logic [31:0] stop;
  } seq_range_t;

  // a is before b when the modular distance a-b is negative
  function automatic logic seq_before(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    return diff[31];
  endfunction

endpackage

// File: rtl/tcp_vlg_rx_seq_trk_ooo_tbl.sv
// Out-of-order range table: OOO_DEPTH slots per channel, one write port,
// a per-channel clear, a combinational read port and per-channel searches
// for the lowest free slot and for an identical stored range.
module tcp_vlg_rx_ooo_tbl
  import tcp_vlg_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int OOO_DEPTH = 4,
  parameter int CH_W      = 2,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_en,
  input  logic [CH_W-1:0]  clr_ch,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [IDX_W-1:0] wr_idx,
  input  seq_range_t       wr_ent,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [IDX_W-1:0] rd_idx,
  output seq_range_t       rd_ent,
  input  logic [CH_W-1:0]  qry_ch,
  input  logic [31:0]      qry_start,
  input  logic [31:0]      qry_stop,
  output logic             qry_free,
  output logic [IDX_W-1:0] qry_free_idx,
  output logic             qry_dup,
  output logic             qry_any
);

  localparam int ENTRIES = CHANNELS * OOO_DEPTH;

  seq_range_t slot_q [ENTRIES];

  // One register per slot; a channel clear wins over a slot write
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ent
      localparam logic [CH_W-1:0]  ENT_CH  = CH_W'(gi / OOO_DEPTH);
      localparam logic [IDX_W-1:0] ENT_IDX = IDX_W'(gi % OOO_DEPTH);
      seq_range_t ent_reg;

      // Slot state update
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ent_reg <= '0;
        end else if (clr_en && (clr_ch == ENT_CH)) begin
          ent_reg <= '0;
        end else if (wr_en && (wr_ch == ENT_CH) && (wr_idx == ENT_IDX)) begin
          ent_reg <= wr_ent;
        end
      end

      assign slot_q[gi] = ent_reg;
    end
  endgenerate

  // Read mux for the merge scanner
  always_comb begin
    rd_ent = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if ((rd_ch == CH_W'(i / OOO_DEPTH)) && (rd_idx == IDX_W'(i % OOO_DEPTH))) begin
        rd_ent = slot_q[i];
      end
    end
  end

  // Free-slot, duplicate and occupancy search over the queried channel
  always_comb begin
    qry_free     = 1'b0;
    qry_free_idx = '0;
    qry_dup      = 1'b0;
    qry_any      = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (qry_ch == CH_W'(i / OOO_DEPTH)) begin
        if (slot_q[i].val) begin
          qry_any = 1'b1;
          if ((slot_q[i].start == qry_start) && (slot_q[i].stop == qry_stop)) begin
            qry_dup = 1'b1;
          end
        end else if (!qry_free) begin
          qry_free     = 1'b1;
          qry_free_idx = IDX_W'(i % OOO_DEPTH);
        end
      end
    end
  end

endmodule

// File: rtl/tcp_vlg_rx_seq_trk.sv
// TCP receive sequence tracker: per-channel expected sequence number,
// segment classification, out-of-order range merge and saturating stats.
module tcp_vlg_rx_seq_trk
  import tcp_vlg_pkg::*;
#(
  parameter int   CHANNELS  = 4,
  parameter int   OOO_DEPTH = 4,
  parameter int   CNT_W     = 16,
  localparam int  CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_val,
  input  logic [CH_W-1:0]  init_ch,
  input  logic [31:0]      init_seq,
  input  logic             seg_val,
  output logic             seg_rdy,
  input  logic [CH_W-1:0]  seg_ch,
  input  logic [31:0]      seg_seq,
  input  logic [15:0]      seg_len,
  output logic             res_val,
  output logic [CH_W-1:0]  res_ch,
  output logic [31:0]      res_ack,
  output seq_class_t       res_class,
  input  logic [CH_W-1:0]  cnt_rd_ch,
  output logic [CNT_W-1:0] cnt_in_order,
  output logic [CNT_W-1:0] cnt_dup,
  output logic [CNT_W-1:0] cnt_ooo,
  output logic [CNT_W-1:0] cnt_drop
);

  localparam int IDX_W = (OOO_DEPTH > 1) ? $clog2(OOO_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OOO_DEPTH - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLASSIFY = 2'd1;
  localparam logic [1:0] S_MERGE    = 2'd2;
  localparam logic [1:0] S_REPORT   = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [31:0]      exp_reg      [CHANNELS];
  logic [CNT_W-1:0] cnt_io_reg   [CHANNELS];
  logic [CNT_W-1:0] cnt_dup_reg  [CHANNELS];
  logic [CNT_W-1:0] cnt_ooo_reg  [CHANNELS];
  logic [CNT_W-1:0] cnt_drop_reg [CHANNELS];
  logic [CHANNELS-1:0] open_reg;

  logic [CH_W-1:0]  seg_ch_reg;
  logic [31:0]      seg_seq_reg;
  logic [15:0]      seg_len_reg;
  logic [31:0]      cur_exp_reg;
  seq_class_t       res_class_reg;
  logic [IDX_W-1:0] scan_idx_reg, pass_reg;
  logic             changed_reg;

  logic             tbl_free, tbl_dup, tbl_any, tbl_wr_en;
  logic [IDX_W-1:0] tbl_free_idx, tbl_wr_idx;
  seq_range_t       tbl_wr_ent, mrg_ent;

  logic [31:0] cls_exp, cls_exp_next, seg_end, mrg_exp;
  seq_class_t  cls_class;
  logic        cls_store, mrg_hit, mrg_last, mrg_again;

  assign seg_rdy   = (state_reg == S_IDLE) && !init_val;
  assign res_val   = (state_reg == S_REPORT);
  assign res_ch    = seg_ch_reg;
  assign res_ack   = cur_exp_reg;
  assign res_class = res_class_reg;

  assign cls_exp = exp_reg[seg_ch_reg];
  assign seg_end = seg_seq_reg + 32'(seg_len_reg);

  // Classify the latched segment against the channel's expected seq
  always_comb begin
    cls_class    = EMPTY;
    cls_exp_next = cls_exp;
    cls_store    = 1'b0;
    if (!open_reg[seg_ch_reg]) begin
      cls_class = DROP;
    end else if (seg_len_reg == 16'd0) begin
      cls_class = EMPTY;
    end else if ((seg_seq_reg == cls_exp) ||
                 (seq_before(seg_seq_reg, cls_exp) && seq_before(cls_exp, seg_end))) begin
      cls_class    = IN_ORDER;
      cls_exp_next = seg_end;
    end else if (!seq_before(cls_exp, seg_end)) begin
      cls_class = DUP;
    end else if (tbl_dup) begin
      cls_class = OOO;
    end else if (tbl_free) begin
      cls_class = OOO;
      cls_store = 1'b1;
    end else begin
      cls_class = DROP;
    end
  end

  // A slot merges when it starts at or before exp; exp only ever grows
  assign mrg_hit   = mrg_ent.val && !seq_before(cur_exp_reg, mrg_ent.start);
  assign mrg_exp   = (mrg_hit && seq_before(cur_exp_reg, mrg_ent.stop)) ? mrg_ent.stop : cur_exp_reg;
  assign mrg_last  = (scan_idx_reg == LAST_IDX);
  assign mrg_again = (changed_reg || mrg_hit) && (pass_reg != LAST_IDX);

  // Table write: store a new OOO range in CLASSIFY, invalidate merged slots in MERGE
  always_comb begin
    tbl_wr_en  = ((state_reg == S_CLASSIFY) && cls_store) || ((state_reg == S_MERGE) && mrg_hit);
    tbl_wr_idx = (state_reg == S_MERGE) ? scan_idx_reg : tbl_free_idx;
    tbl_wr_ent = '0;
    if (state_reg == S_CLASSIFY) begin
      tbl_wr_ent.val   = 1'b1;
      tbl_wr_ent.start = seg_seq_reg;
      tbl_wr_ent.stop  = seg_end;
    end
  end

  tcp_vlg_rx_ooo_tbl #(
    .CHANNELS  (CHANNELS),
    .OOO_DEPTH (OOO_DEPTH),
    .CH_W      (CH_W),
    .IDX_W     (IDX_W)
  ) u_ooo_tbl (
    .clk          (clk),
    .rst          (rst),
    .clr_en       ((state_reg == S_IDLE) && init_val),
    .clr_ch       (init_ch),
    .wr_en        (tbl_wr_en),
    .wr_ch        (seg_ch_reg),
    .wr_idx       (tbl_wr_idx),
    .wr_ent       (tbl_wr_ent),
    .rd_ch        (seg_ch_reg),
    .rd_idx       (scan_idx_reg),
    .rd_ent       (mrg_ent),
    .qry_ch       (seg_ch_reg),
    .qry_start    (seg_seq_reg),
    .qry_stop     (seg_end),
    .qry_free     (tbl_free),
    .qry_free_idx (tbl_free_idx),
    .qry_dup      (tbl_dup),
    .qry_any      (tbl_any)
  );

  // Next-state logic; an in-order segment skips MERGE when its channel holds no ranges
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (!init_val && seg_val) state_next = S_CLASSIFY;
      S_CLASSIFY: state_next = ((cls_class == IN_ORDER) && tbl_any) ? S_MERGE : S_REPORT;
      S_MERGE:    if (mrg_last && !mrg_again) state_next = S_REPORT;
      default:    state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Segment latch, working exp and merge scan bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_ch_reg    <= '0;
      seg_seq_reg   <= '0;
      seg_len_reg   <= '0;
      cur_exp_reg   <= '0;
      res_class_reg <= EMPTY;
      scan_idx_reg  <= '0;
      pass_reg      <= '0;
      changed_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (seg_rdy && seg_val) begin
            seg_ch_reg  <= seg_ch;
            seg_seq_reg <= seg_seq;
            seg_len_reg <= seg_len;
          end
        end
        S_CLASSIFY: begin
          cur_exp_reg   <= cls_exp_next;
          res_class_reg <= cls_class;
          scan_idx_reg  <= '0;
          pass_reg      <= '0;
          changed_reg   <= 1'b0;
        end
        S_MERGE: begin
          cur_exp_reg <= mrg_exp;
          if (mrg_last) begin
            scan_idx_reg <= '0;
            pass_reg     <= pass_reg + IDX_W'(1);
            changed_reg  <= 1'b0;
          end else begin
            scan_idx_reg <= scan_idx_reg + IDX_W'(1);
            changed_reg  <= changed_reg || mrg_hit;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel open flag, expected seq and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      open_reg <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        exp_reg[c]      <= '0;
        cnt_io_reg[c]   <= '0;
        cnt_dup_reg[c]  <= '0;
        cnt_ooo_reg[c]  <= '0;
        cnt_drop_reg[c] <= '0;
      end
    end else if ((state_reg == S_IDLE) && init_val) begin
      open_reg[init_ch]     <= 1'b1;
      exp_reg[init_ch]      <= init_seq;
      cnt_io_reg[init_ch]   <= '0;
      cnt_dup_reg[init_ch]  <= '0;
      cnt_ooo_reg[init_ch]  <= '0;
      cnt_drop_reg[init_ch] <= '0;
    end else if (state_reg == S_REPORT) begin
      exp_reg[seg_ch_reg] <= cur_exp_reg;
      case (res_class_reg)
        IN_ORDER: if (cnt_io_reg[seg_ch_reg] != '1)
                    cnt_io_reg[seg_ch_reg] <= cnt_io_reg[seg_ch_reg] + CNT_W'(1);
        DUP:      if (cnt_dup_reg[seg_ch_reg] != '1)
                    cnt_dup_reg[seg_ch_reg] <= cnt_dup_reg[seg_ch_reg] + CNT_W'(1);
        OOO:      if (cnt_ooo_reg[seg_ch_reg] != '1)
                    cnt_ooo_reg[seg_ch_reg] <= cnt_ooo_reg[seg_ch_reg] + CNT_W'(1);
        DROP:     if (cnt_drop_reg[seg_ch_reg] != '1)
                    cnt_drop_reg[seg_ch_reg] <= cnt_drop_reg[seg_ch_reg] + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Registered statistics readout for the selected channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_in_order <= '0;
      cnt_dup      <= '0;
      cnt_ooo      <= '0;
      cnt_drop     <= '0;
    end else begin
      cnt_in_order <= cnt_io_reg[cnt_rd_ch];
      cnt_dup      <= cnt_dup_reg[cnt_rd_ch];
      cnt_ooo      <= cnt_ooo_reg[cnt_rd_ch];
      cnt_drop     <= cnt_drop_reg[cnt_rd_ch];
    end
  end

endmodule

// File: tb/tb_tcp_vlg_rx_seq_trk.sv
// Scoreboard bench for tcp_vlg_rx_seq_trk: directed segments push expected
// results; a negedge monitor pops and checks channel, ack, class and latency.
module tb_tcp_vlg_rx_seq_trk;
  import tcp_vlg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_val = 1'b0;
  logic [1:0]  init_ch = '0;
  logic [31:0] init_seq = '0;
  logic        seg_val = 1'b0;
  logic        seg_rdy;
  logic [1:0]  seg_ch = '0;
  logic [31:0] seg_seq = '0;
  logic [15:0] seg_len = '0;
  logic        res_val;
  logic [1:0]  res_ch;
  logic [31:0] res_ack;
  seq_class_t  res_class;
  logic [1:0]  cnt_rd_ch = '0;
  logic [15:0] cnt_in_order, cnt_dup, cnt_ooo, cnt_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          ch;
    logic [31:0] ack;
    int          cls;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  tcp_vlg_rx_seq_trk #(.CHANNELS(4), .OOO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .init_val(init_val), .init_ch(init_ch), .init_seq(init_seq),
    .seg_val(seg_val), .seg_rdy(seg_rdy), .seg_ch(seg_ch), .seg_seq(seg_seq), .seg_len(seg_len),
    .res_val(res_val), .res_ch(res_ch), .res_ack(res_ack), .res_class(res_class),
    .cnt_rd_ch(cnt_rd_ch), .cnt_in_order(cnt_in_order), .cnt_dup(cnt_dup),
    .cnt_ooo(cnt_ooo), .cnt_drop(cnt_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) required %0d (0x%08h)", name, act, act, req, req);
    end
  endtask

  // Monitor: every result strobe must match the oldest expectation
  always @(negedge clk) begin
    if (rst && res_val) begin
      if (sb.size() == 0) begin
        chk("res_val_unexpected", {31'b0, res_val}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("res ch=%0d class=%0d ack=0x%08h latency=%0d", res_ch, res_class, res_ack, cyc - mon_e.acc);
        chk("res_ch", {30'b0, res_ch}, mon_e.ch);
        chk("res_ack", res_ack, mon_e.ack);
        chk("res_class", {29'b0, res_class}, mon_e.cls);
        chk("res_latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic do_init(input int ch, input logic [31:0] seq);
    @(negedge clk);
    init_val = 1'b1;
    init_ch  = 2'(ch);
    init_seq = seq;
    @(posedge clk);
    #1 init_val = 1'b0;
  endtask

  task automatic send(input int ch, input logic [31:0] seq, input int len,
                      input logic [31:0] ack, input int cls, input int lat, input bit push);
    bit done;
    done = 1'b0;
    @(negedge clk);
    seg_val = 1'b1;
    seg_ch  = 2'(ch);
    seg_seq = seq;
    seg_len = 16'(len);
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (seg_rdy) begin
        if (push) sb.push_back('{ch, ack, cls, cyc, lat});
        done = 1'b1;
        @(posedge clk);
        #1 seg_val = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      chk("seg_accept_timeout", {31'b0, seg_rdy}, 32'd1);
      seg_val = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk("result_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_cnt(input int ch, input int io, input int dup, input int ooo, input int drop);
    @(negedge clk);
    cnt_rd_ch = 2'(ch);
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("cnt_in_order_ch%0d", ch), {16'b0, cnt_in_order}, io);
    chk($sformatf("cnt_dup_ch%0d", ch), {16'b0, cnt_dup}, dup);
    chk($sformatf("cnt_ooo_ch%0d", ch), {16'b0, cnt_ooo}, ooo);
    chk($sformatf("cnt_drop_ch%0d", ch), {16'b0, cnt_drop}, drop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_seg_rdy", {31'b0, seg_rdy}, 32'd1);
    chk("reset_res_val", {31'b0, res_val}, 32'd0);
    chk("reset_res_ch", {30'b0, res_ch}, 32'd0);
    chk("reset_res_ack", res_ack, 32'd0);
    chk("reset_res_class", {29'b0, res_class}, 32'd0);
    chk_cnt(0, 0, 0, 0, 0);

    // ch0: in order, then a hole filled by one merge
    do_init(0, 32'd1000);
    send(0, 32'd1000, 100, 32'd1100, 1, 2, 1); drain();
    chk_cnt(0, 1, 0, 0, 0);
    send(0, 32'd1300, 50, 32'd1100, 3, 2, 1); drain();
    send(0, 32'd1100, 200, 32'd1350, 1, 10, 1); drain();
    send(0, 32'd1350, 0, 32'd1350, 0, 2, 1); drain();
    chk_cnt(0, 2, 0, 1, 0);

    // ch2: sequence wrap
    do_init(2, 32'hFFFF_FFF0);
    send(2, 32'hFFFF_FFF0, 32, 32'h0000_0010, 1, 2, 1); drain();
    send(2, 32'hFFFF_FFF8, 8, 32'h0000_0010, 2, 2, 1); drain();
    chk_cnt(2, 1, 1, 0, 0);

    // ch1: fill all slots in reverse order, overflow, duplicate, then merge over 4 passes
    do_init(1, 32'd0);
    send(1, 32'd400, 100, 32'd0, 3, 2, 1); drain();
    send(1, 32'd300, 100, 32'd0, 3, 2, 1); drain();
    send(1, 32'd200, 100, 32'd0, 3, 2, 1); drain();
    send(1, 32'd100, 100, 32'd0, 3, 2, 1); drain();
    send(1, 32'd600, 100, 32'd0, 4, 2, 1); drain();
    send(1, 32'd200, 100, 32'd0, 3, 2, 1); drain();
    send(1, 32'd0, 100, 32'd500, 1, 18, 1); drain();
    send(1, 32'd600, 10, 32'd500, 3, 2, 1); drain();
    chk_cnt(1, 1, 0, 6, 1);

    // ch1: init and segment together; init wins, slots and counters are cleared
    @(negedge clk);
    init_val = 1'b1; init_ch = 2'd1; init_seq = 32'd5000;
    seg_val = 1'b1; seg_ch = 2'd1; seg_seq = 32'd5000; seg_len = 16'd10;
    #1 chk("seg_rdy_during_init", {31'b0, seg_rdy}, 32'd0);
    @(posedge clk);
    #1 init_val = 1'b0;
    @(negedge clk);
    chk("seg_rdy_after_init", {31'b0, seg_rdy}, 32'd1);
    sb.push_back('{1, 32'd5010, 1, cyc, 2});
    @(posedge clk);
    #1 seg_val = 1'b0;
    drain();
    chk_cnt(1, 1, 0, 0, 0);

    // ch3 never opened
    send(3, 32'd0, 10, 32'd0, 4, 2, 1); drain();
    chk_cnt(3, 0, 0, 0, 1);

    // reset in the middle of a merge: no result, everything cleared
    send(0, 32'd1400, 10, 32'd1350, 3, 2, 1); drain();
    send(0, 32'd1350, 10, 32'd0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_seg_rdy", {31'b0, seg_rdy}, 32'd1);
    chk("post_reset_res_val", {31'b0, res_val}, 32'd0);
    chk("post_reset_res_ack", res_ack, 32'd0);
    for (int c = 0; c < 4; c++) chk_cnt(c, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
